// File: rtl/approx_add_err_monitor.sv
// Error-metric accumulator for 16-bit approximate adders: per window it collects
// sum of |error|, max |error| and erroneous-sample count. Optional macro ERR_WORST_CAPTURE_EN.
module approx_add_err_monitor #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CNT_W-1:0]         len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [WIDTH:0]           in_approx,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH+CNT_W:0]     err_sum,
  output logic [WIDTH:0]           err_max,
  output logic [CNT_W-1:0]         err_cnt
`ifdef ERR_WORST_CAPTURE_EN
  ,
  output logic [WIDTH-1:0]         worst_a,
  output logic [WIDTH-1:0]         worst_b
`endif
);

  localparam int DW    = WIDTH + 1;
  localparam int SUM_W = WIDTH + 1 + CNT_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   remaining_q;
  logic [DW-1:0]      diff_q;
  logic               diff_v_q;
  logic [SUM_W-1:0]   err_sum_q;
  logic [DW-1:0]      err_max_q;
  logic [CNT_W-1:0]   err_cnt_q;

  logic               accept;
  logic               start_go;
  logic [WIDTH+1:0]   diff_raw;
  logic [DW-1:0]      diff_mag;

  assign accept   = in_valid & in_ready;
  assign start_go = start & (state_q == S_IDLE);

  // Exact sum minus approximate result at WIDTH+2 bits; the top bit is the sign.
  assign diff_raw = ({2'b00, in_a} + {2'b00, in_b}) - {1'b0, in_approx};
  assign diff_mag = diff_raw[WIDTH+1] ? DW'(-diff_raw) : diff_raw[WIDTH:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (len != '0) ? S_RUN : S_DONE;
      S_RUN:   if (accept && remaining_q == CNT_W'(1)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_RUN);
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
  end

  // Stage 1: register the absolute error of each accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
      diff_q      <= '0;
      diff_v_q    <= 1'b0;
    end else if (start_go) begin
      remaining_q <= len;
      diff_v_q    <= 1'b0;
    end else if (accept) begin
      remaining_q <= remaining_q - CNT_W'(1);
      diff_q      <= diff_mag;
      diff_v_q    <= 1'b1;
    end else begin
      diff_v_q    <= 1'b0;
    end
  end

  // Stage 2: fold the registered error into the window statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sum_q <= '0;
      err_max_q <= '0;
      err_cnt_q <= '0;
    end else if (start_go) begin
      err_sum_q <= '0;
      err_max_q <= '0;
      err_cnt_q <= '0;
    end else if (diff_v_q) begin
      err_sum_q <= err_sum_q + SUM_W'(diff_q);
      if (diff_q > err_max_q) err_max_q <= diff_q;
      if (diff_q != '0)       err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign err_sum = err_sum_q;
  assign err_max = err_max_q;
  assign err_cnt = err_cnt_q;

`ifdef ERR_WORST_CAPTURE_EN
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic [WIDTH-1:0] worst_a_q, worst_b_q;

  // Strict greater-than keeps the first sample that reaches the maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      worst_a_q <= '0;
      worst_b_q <= '0;
    end else begin
      if (accept) begin
        op_a_q <= in_a;
        op_b_q <= in_b;
      end
      if (start_go) begin
        worst_a_q <= '0;
        worst_b_q <= '0;
      end else if (diff_v_q && diff_q > err_max_q) begin
        worst_a_q <= op_a_q;
        worst_b_q <= op_b_q;
      end
    end
  end

  assign worst_a = worst_a_q;
  assign worst_b = worst_b_q;
`endif

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Self-checking bench for approx_add_err_monitor: vector table, hand-written
// corner sequences and randomized windows against an arithmetic reference model.
module tb_approx_add_err_monitor;

  localparam int WIDTH = 16;
  localparam int CNT_W = 16;
  localparam int SUM_W = WIDTH + 1 + CNT_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [CNT_W-1:0]   len;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a, in_b;
  logic [WIDTH:0]     in_approx;
  logic               busy, done;
  logic [SUM_W-1:0]   err_sum;
  logic [WIDTH:0]     err_max;
  logic [CNT_W-1:0]   err_cnt;
`ifdef ERR_WORST_CAPTURE_EN
  logic [WIDTH-1:0]   worst_a, worst_b;
`endif

  approx_add_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_approx (in_approx),
    .busy      (busy),
    .done      (done),
    .err_sum   (err_sum),
    .err_max   (err_max),
    .err_cnt   (err_cnt)
`ifdef ERR_WORST_CAPTURE_EN
    ,
    .worst_a   (worst_a),
    .worst_b   (worst_b)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;

  always @(negedge clk) if (done) done_pulses++;

  logic [WIDTH-1:0] qa[$], qb[$];
  logic [WIDTH:0]   qap[$];

  typedef struct {
    int               n;
    logic [WIDTH-1:0] a[4];
    logic [WIDTH-1:0] b[4];
    logic [WIDTH:0]   ap[4];
    logic [SUM_W-1:0] e_sum;
    logic [WIDTH:0]   e_max;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_results(input string tag, input logic [SUM_W-1:0] s,
                               input logic [WIDTH:0] m, input logic [CNT_W-1:0] c);
    check({tag, "_err_sum"}, 64'(err_sum), 64'(s));
    check({tag, "_err_max"}, 64'(err_max), 64'(m));
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(c));
  endtask

  // Reference: plain integer arithmetic over the queued samples.
  function automatic void model(output logic [SUM_W-1:0] s, output logic [WIDTH:0] m,
                                output logic [CNT_W-1:0] c);
    longint acc = 0;
    int     mx = 0;
    int     nz = 0;
    foreach (qa[i]) begin
      int d = int'(qa[i]) + int'(qb[i]) - int'(qap[i]);
      if (d < 0) d = -d;
      acc += d;
      if (d > mx) mx = d;
      if (d != 0) nz++;
    end
    s = SUM_W'(acc);
    m = (WIDTH+1)'(mx);
    c = CNT_W'(nz);
  endfunction

  // Starts a window over the queued samples and stops on the negedge where done is high.
  task automatic run_window(input int n, input int gap_max, input string tag);
    int guard;
    int gap;
    @(negedge clk);
    start = 1'b1;
    len   = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    len   = '0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    if (n == 0) begin
      check({tag, "_done_len0"}, 64'(done), 64'd1);
      return;
    end
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (gap) @(negedge clk);
      in_a = qa[i]; in_b = qb[i]; in_approx = qap[i];
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        check({tag, "_ready_timeout"}, 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
    check({tag, "_drain_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_drain_nodone"}, 64'(done), 64'd0);
    @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic after_done(input string tag, input logic [SUM_W-1:0] s,
                            input logic [WIDTH:0] m, input logic [CNT_W-1:0] c);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check_results({tag, "_hold"}, s, m, c);
  endtask

  task automatic clear_q();
    qa.delete(); qb.delete(); qap.delete();
  endtask

  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH:0] ap);
    qa.push_back(a); qb.push_back(b); qap.push_back(ap);
  endtask

  initial begin
    logic [SUM_W-1:0] es;
    logic [WIDTH:0]   em;
    logic [CNT_W-1:0] ec;
    logic [WIDTH:0]   ex;
    int               pulses_before;

    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_approx = '0;

    tbl[0].n = 4;
    tbl[0].a  = '{16'd1, 16'hFFFF, 16'h1234, 16'hFFFF};
    tbl[0].b  = '{16'd2, 16'h0001, 16'h4321, 16'hFFFF};
    tbl[0].ap = '{17'd3, 17'h10000, 17'h05555, 17'h1FFFE};
    tbl[0].e_sum = '0; tbl[0].e_max = '0; tbl[0].e_cnt = '0;

    tbl[1].n = 3;
    tbl[1].a  = '{16'd3, 16'd0, 16'hFFFF, 16'd0};
    tbl[1].b  = '{16'd1, 16'd0, 16'hFFFF, 16'd0};
    tbl[1].ap = '{17'd2, 17'd1, 17'h1FFFE, 17'd0};
    tbl[1].e_sum = 33'd3; tbl[1].e_max = 17'd2; tbl[1].e_cnt = 16'd2;

    tbl[2].n = 1;
    tbl[2].a  = '{16'd0, 16'd0, 16'd0, 16'd0};
    tbl[2].b  = '{16'd0, 16'd0, 16'd0, 16'd0};
    tbl[2].ap = '{17'h1FFFF, 17'd0, 17'd0, 17'd0};
    tbl[2].e_sum = 33'h1FFFF; tbl[2].e_max = 17'h1FFFF; tbl[2].e_cnt = 16'd1;

    tbl[3].n = 2;
    tbl[3].a  = '{16'hFFFF, 16'd5, 16'd0, 16'd0};
    tbl[3].b  = '{16'hFFFF, 16'd5, 16'd0, 16'd0};
    tbl[3].ap = '{17'd0, 17'd10, 17'd0, 17'd0};
    tbl[3].e_sum = 33'h1FFFE; tbl[3].e_max = 17'h1FFFE; tbl[3].e_cnt = 16'd1;

    tbl[4].n = 2;
    tbl[4].a  = '{16'd10, 16'd0, 16'd0, 16'd0};
    tbl[4].b  = '{16'd0, 16'd0, 16'd0, 16'd0};
    tbl[4].ap = '{17'd4, 17'd3, 17'd0, 17'd0};
    tbl[4].e_sum = 33'd9; tbl[4].e_max = 17'd6; tbl[4].e_cnt = 16'd2;

    // Reset state
    #12;
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check_results("reset", '0, '0, '0);
`ifdef ERR_WORST_CAPTURE_EN
    check("reset_worst_a", 64'(worst_a), 64'd0);
    check("reset_worst_b", 64'(worst_b), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    foreach (tbl[k]) begin
      clear_q();
      for (int i = 0; i < tbl[k].n; i++) push(tbl[k].a[i], tbl[k].b[i], tbl[k].ap[i]);
      run_window(tbl[k].n, 0, $sformatf("vec%0d", k));
      check_results($sformatf("vec%0d", k), tbl[k].e_sum, tbl[k].e_max, tbl[k].e_cnt);
      after_done($sformatf("vec%0d", k), tbl[k].e_sum, tbl[k].e_max, tbl[k].e_cnt);
    end

    // len = 0 right after a window with nonzero results
    clear_q();
    run_window(0, 0, "len0");
    check_results("len0", '0, '0, '0);
    after_done("len0", '0, '0, '0);

    // len = 2 with in_valid gaps; extra valid in DRAIN/DONE is not consumed
    @(negedge clk);
    start = 1'b1; len = 16'd2;
    @(negedge clk);
    start = 1'b0;
    in_a = 16'd3; in_b = 16'd1; in_approx = 17'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("gap_ready_idle_cycle", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_a = 16'd10; in_b = 16'd0; in_approx = 17'd7; in_valid = 1'b1;
    @(negedge clk);
    in_a = 16'd0; in_b = 16'd0; in_approx = 17'h1FFFF;
    check("gap_drain_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("gap_done", 64'(done), 64'd1);
    check("gap_done_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("gap_idle_busy", 64'(busy), 64'd0);
    check_results("gap", 33'd5, 17'd3, 16'd2);

    // start pulsed during RUN is ignored
    @(negedge clk);
    start = 1'b1; len = 16'd3;
    @(negedge clk);
    start = 1'b0;
    in_a = 16'd1; in_b = 16'd1; in_approx = 17'd3; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b1; len = 16'd1;
    in_a = 16'd2; in_b = 16'd2; in_approx = 17'd3;
    @(negedge clk);
    start = 1'b0; len = '0;
    in_a = 16'd7; in_b = 16'd0; in_approx = 17'd8;
    @(negedge clk);
    in_valid = 1'b0;
    check("restart_drain_ready", 64'(in_ready), 64'd0);
    check("restart_drain_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("restart_done", 64'(done), 64'd1);
    check_results("restart", 33'd3, 17'd1, 16'd3);

    // Asynchronous reset mid-window after 2 of 5 samples
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; len = 16'd5;
    @(negedge clk);
    start = 1'b0;
    in_a = 16'd5; in_b = 16'd0; in_approx = 17'd2; in_valid = 1'b1;
    @(negedge clk);
    in_a = 16'd6; in_b = 16'd0; in_approx = 17'd10;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_results("partial", 33'd7, 17'd4, 16'd2);
    pulses_before = done_pulses;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check_results("midrst", '0, '0, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("midrst_no_done_pulse", 64'(done_pulses), 64'(pulses_before));
    check("midrst_still_idle", 64'(busy), 64'd0);
    clear_q();
    push(16'd5, 16'd0, 17'd0);
    run_window(1, 0, "post_rst");
    check_results("post_rst", 33'd5, 17'd5, 16'd1);
    after_done("post_rst", 33'd5, 17'd5, 16'd1);

`ifdef ERR_WORST_CAPTURE_EN
    // Errors 1, 7, 7: the first error-7 sample's operands are kept
    clear_q();
    push(16'd1, 16'd1, 17'd1);
    push(16'd10, 16'd2, 17'd5);
    push(16'd20, 16'd4, 17'd17);
    run_window(3, 0, "worst");
    check("worst_err_max", 64'(err_max), 64'd7);
    check("worst_a", 64'(worst_a), 64'd10);
    check("worst_b", 64'(worst_b), 64'd2);
`endif

    // Randomized windows against the reference model
    for (int w = 0; w < 40; w++) begin
      int n;
      n = int'($urandom_range(1, 8));
      clear_q();
      for (int i = 0; i < n; i++) begin
        logic [WIDTH-1:0] a, b;
        logic [WIDTH:0]   ap;
        a  = WIDTH'($urandom);
        b  = WIDTH'($urandom);
        ex = {1'b0, a} + {1'b0, b};
        case ($urandom_range(0, 3))
          0:       ap = ex;
          1:       ap = ex ^ (17'd1 << $urandom_range(0, 5));
          2:       ap = ex & ~17'h7;
          default: ap = (WIDTH+1)'($urandom);
        endcase
        push(a, b, ap);
      end
      model(es, em, ec);
      run_window(n, (w % 2) * 2, $sformatf("rnd%0d", w));
      check_results($sformatf("rnd%0d", w), es, em, ec);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
